// File: rtl/core_mc.sv
// core_mc: multi-cycle RV32I core (no FENCE/ECALL/EBREAK/CSR).
// One instruction at a time walks FETCH -> EXEC [-> MEM] -> FETCH.
// Illegal opcodes, misaligned taken targets and misaligned loads/stores
// park the core in HALT until reset.
//
// Ports:
//   clk, rst        clock (posedge), asynchronous active-high reset
//   o_instr_addr    fetch word address (= pc)
//   o_instr_req     fetch request, gated low while rst is high
//   i_instr_ready   fetch accept; i_instr_data valid in the same cycle
//   i_instr_data    instruction word
//   o_mem_addr      data word address
//   o_mem_req       data request
//   o_mem_we        store strobe (qualified by o_mem_req)
//   o_mem_mask      byte-lane enables for loads and stores
//   o_mem_data      store data, replicated across lanes
//   i_mem_ready     data accept; i_mem_data valid in the same cycle
//   i_mem_data      load word
//   o_halted        core stopped on a fault
//   o_retired       retired-instruction count (wraps at 2^32)
//
// ADDR_W is at most 30 so that a word address fits a 32-bit byte address.
module core_mc #(
  parameter int                ADDR_W   = 30,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] o_instr_addr,
  output logic              o_instr_req,
  input  logic              i_instr_ready,
  input  logic [31:0]       i_instr_data,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [3:0]        o_mem_mask,
  output logic [31:0]       o_mem_data,
  input  logic              i_mem_ready,
  input  logic [31:0]       i_mem_data,
  output logic              o_halted,
  output logic [31:0]       o_retired
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_e;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       retired_q, retired_d;
  logic              we_q, we_d;
  logic [31:0]       ea_q, ea_d;
  logic [31:0]       sdata_q, sdata_d;
  logic [3:0]        mask_q, mask_d;

  logic [31:0]       rf_q [32];
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [31:0]       rf_wdata;

  // ---------------------------------------------------------------- decode
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1v, rs2v, pc_byte;
  logic        legal, is_mem, is_store, misaligned, taken;
  logic [31:0] target, wb, ea, lane, load_val;
  logic [3:0]  mask;
  logic [31:0] sdata;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign f3     = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign f7     = ir_q[31:25];

  assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u = {ir_q[31:12], 12'b0};
  assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  assign rs1v    = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
  assign rs2v    = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
  assign pc_byte = 32'({pc_q, 2'b00});

  function automatic logic [31:0] alu(input logic [2:0] f, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (f)
      3'b000:  alu = alt ? (a - b) : (a + b);
      3'b001:  alu = a << sh;
      3'b010:  alu = {31'd0, $signed(a) < $signed(b)};
      3'b011:  alu = {31'd0, a < b};
      3'b100:  alu = a ^ b;
      3'b101:  alu = alt ? 32'($signed(a) >>> sh) : (a >> sh);
      3'b110:  alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  function automatic logic cbu(input logic [2:0] f, input logic [31:0] a,
                               input logic [31:0] b);
    case (f)
      3'b000:  cbu = (a == b);
      3'b001:  cbu = (a != b);
      3'b100:  cbu = ($signed(a) <  $signed(b));
      3'b101:  cbu = ($signed(a) >= $signed(b));
      3'b110:  cbu = (a <  b);
      3'b111:  cbu = (a >= b);
      default: cbu = 1'b0;
    endcase
  endfunction

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL: legal = 1'b1;
      OP_JALR:  legal = (f3 == 3'b000);
      OP_BR:    legal = (f3 != 3'b010) && (f3 != 3'b011);
      OP_LOAD:  legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      OP_STORE: legal = f3 inside {3'b000, 3'b001, 3'b010};
      OP_IMM: begin
        if (f3 == 3'b001)      legal = (f7 == 7'd0);
        else if (f3 == 3'b101) legal = (f7 == 7'd0) || (f7 == 7'b0100000);
        else                   legal = 1'b1;
      end
      OP_REG: legal = (f7 == 7'd0) ||
                      ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
      default: legal = 1'b0;
    endcase
  end

  // Control flow, writeback value and memory operands for the current ir.
  always_comb begin
    taken  = 1'b0;
    target = pc_byte + imm_b;
    wb     = 32'd0;
    case (opcode)
      OP_LUI:   wb = imm_u;
      OP_AUIPC: wb = pc_byte + imm_u;
      OP_JAL: begin
        taken  = 1'b1;
        target = pc_byte + imm_j;
        wb     = pc_byte + 32'd4;
      end
      OP_JALR: begin
        taken  = 1'b1;
        target = (rs1v + imm_i) & ~32'd1;
        wb     = pc_byte + 32'd4;
      end
      OP_BR:  taken = cbu(f3, rs1v, rs2v);
      OP_REG: wb = alu(f3, f7[5], rs1v, rs2v);
      // ADDI with a negative immediate has ir[30] set, so only SRAI may subtract/shift arithmetically.
      OP_IMM: wb = alu(f3, (f3 == 3'b101) && f7[5], rs1v, imm_i);
      default: ;
    endcase
  end

  assign is_store   = (opcode == OP_STORE);
  assign is_mem     = (opcode == OP_LOAD) || is_store;
  assign ea         = rs1v + (is_store ? imm_s : imm_i);
  assign misaligned = ((f3[1:0] == 2'b01) && ea[0]) ||
                      ((f3[1:0] == 2'b10) && (ea[1:0] != 2'b00));

  always_comb begin
    case (f3[1:0])
      2'b00: begin
        mask  = 4'b0001 << ea[1:0];
        sdata = {4{rs2v[7:0]}};
      end
      2'b01: begin
        mask  = 4'b0011 << {ea[1], 1'b0};
        sdata = {2{rs2v[15:0]}};
      end
      default: begin
        mask  = 4'b1111;
        sdata = rs2v;
      end
    endcase
  end

  assign lane = i_mem_data >> {ea_q[1:0], 3'b000};

  always_comb begin
    case (f3)
      3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_val = {24'd0, lane[7:0]};
      3'b101:  load_val = {16'd0, lane[15:0]};
      default: load_val = lane;
    endcase
  end

  // ----------------------------------------------------- next-state logic
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    we_d      = we_q;
    ea_d      = ea_q;
    sdata_d   = sdata_q;
    mask_d    = mask_q;
    rf_we     = 1'b0;
    rf_waddr  = rd;
    rf_wdata  = wb;
    case (state_q)
      S_FETCH: begin
        if (i_instr_ready) begin
          ir_d    = i_instr_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!legal || (taken && (target[1:0] != 2'b00))) begin
          state_d = S_HALT;
        end else if (is_mem) begin
          if (misaligned) begin
            state_d = S_HALT;
          end else begin
            ea_d    = ea;
            sdata_d = sdata;
            mask_d  = mask;
            we_d    = is_store;
            state_d = S_MEM;
          end
        end else begin
          rf_we     = 1'b1;
          pc_d      = taken ? target[ADDR_W+1:2] : pc_q + ADDR_W'(1);
          retired_d = retired_q + 32'd1;
          state_d   = S_FETCH;
        end
      end
      S_MEM: begin
        if (i_mem_ready) begin
          rf_we     = !we_q;
          rf_wdata  = load_val;
          pc_d      = pc_q + ADDR_W'(1);
          retired_d = retired_q + 32'd1;
          state_d   = S_FETCH;
        end
      end
      default: ;
    endcase
  end

  // ------------------------------------------------------------ registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= 32'd0;
      retired_q <= 32'd0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      we_q      <= we_d;
    end
  end

  always_ff @(posedge clk) begin
    ea_q    <= ea_d;
    sdata_q <= sdata_d;
    mask_q  <= mask_d;
  end

  // rf_we can only rise in EXEC/MEM, which reset forces away asynchronously.
  always_ff @(posedge clk) begin
    if (rf_we && (rf_waddr != 5'd0)) rf_q[rf_waddr] <= rf_wdata;
  end

  // -------------------------------------------------------------- outputs
  assign o_instr_addr = pc_q;
  assign o_instr_req  = (state_q == S_FETCH) && !rst;
  assign o_mem_req    = (state_q == S_MEM);
  assign o_mem_we     = o_mem_req && we_q;
  assign o_mem_addr   = ea_q[ADDR_W+1:2];
  assign o_mem_mask   = mask_q;
  assign o_mem_data   = sdata_q;
  assign o_halted     = (state_q == S_HALT);
  assign o_retired    = retired_q;

endmodule

// File: tb/tb_core_mc.sv
// Bench for core_mc: program in a local instruction memory, data memory
// model with controllable ready, store scoreboard filled at program load.
module tb_core_mc;
  localparam int          ADDR_W   = 30;
  localparam logic [29:0] RESET_PC = 30'h10;

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_JALR = 7'b1100111,
                         OP_LOAD = 7'b0000011, OP_IMM = 7'b0010011;

  logic              clk, rst;
  logic [ADDR_W-1:0] o_instr_addr, o_mem_addr;
  logic              o_instr_req, i_instr_ready;
  logic [31:0]       i_instr_data, o_mem_data, i_mem_data, o_retired;
  logic              o_mem_req, o_mem_we, i_mem_ready, o_halted;
  logic [3:0]        o_mem_mask;

  logic [31:0] imem [256];
  logic [31:0] dmem [256];

  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } st_t;
  st_t exp_q [$];

  int n_chk = 0, n_err = 0;
  int mode = 1;          // 0: mem never ready, 1: ready except LH stall, 2: random
  int lh_stall = 3, lh_req_cycles = 0, n_loads = 0;
  int cyc = 0, fetch_cyc = 0, halt_cyc = -1;

  assign i_instr_data = imem[o_instr_addr[7:0]];
  assign i_mem_data   = dmem[o_mem_addr[7:0]];

  core_mc #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .o_instr_addr(o_instr_addr), .o_instr_req(o_instr_req),
    .i_instr_ready(i_instr_ready), .i_instr_data(i_instr_data),
    .o_mem_addr(o_mem_addr), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_mask(o_mem_mask), .o_mem_data(o_mem_data),
    .i_mem_ready(i_mem_ready), .i_mem_data(i_mem_data),
    .o_halted(o_halted), .o_retired(o_retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic push(input logic [29:0] a, input logic [3:0] m, input logic [31:0] d);
    st_t e;
    e.addr = a; e.mask = m; e.data = d;
    exp_q.push_back(e);
  endtask

  // Program starts at byte 0x40 (word 0x10); halts on a misaligned LW at word 0x3B.
  task automatic load_program();
    for (int i = 0; i < 256; i++) begin
      imem[i] = enc_s(12'd28, 5'd9, 5'd0, 3'b010);   // stray store to word 7
      dmem[i] = 32'd0;
    end
    imem[16] = enc_i(12'd5,   5'd0, 3'b000, 5'd1, OP_IMM);   // x1 = 5
    imem[17] = enc_i(12'hFF9, 5'd1, 3'b000, 5'd2, OP_IMM);   // x2 = -2
    imem[18] = enc_s(12'd0,  5'd2, 5'd0, 3'b010);
    imem[19] = enc_i(12'h100, 5'd0, 3'b000, 5'd1, OP_IMM);   // x1 = 0x100
    imem[20] = {20'h12345, 5'd2, OP_LUI};
    imem[21] = enc_i(12'h680, 5'd2, 3'b000, 5'd2, OP_IMM);   // x2 = 0x12345680
    imem[22] = enc_s(12'd3,  5'd2, 5'd1, 3'b000);            // SB x2,3(x1)
    imem[23] = enc_i(12'd3,  5'd1, 3'b000, 5'd3, OP_LOAD);   // LB
    imem[24] = enc_i(12'd3,  5'd1, 3'b100, 5'd4, OP_LOAD);   // LBU
    imem[25] = enc_s(12'd4,  5'd3, 5'd0, 3'b010);
    imem[26] = enc_s(12'd8,  5'd4, 5'd0, 3'b010);
    imem[27] = enc_i(12'd2,  5'd1, 3'b001, 5'd5, OP_LOAD);   // LH ea=0x102
    imem[28] = enc_s(12'd12, 5'd5, 5'd0, 3'b001);            // SH x5,12(x0)
    imem[29] = enc_r(7'b0100000, 5'd3, 5'd4, 3'b000, 5'd6);  // SUB x6,x4,x3
    imem[30] = enc_r(7'd0, 5'd4, 5'd3, 3'b010, 5'd7);        // SLT x7,x3,x4
    imem[31] = enc_i(12'h404, 5'd3, 3'b101, 5'd9, OP_IMM);   // SRAI x9,x3,4
    imem[32] = enc_s(12'd16, 5'd6, 5'd0, 3'b010);
    imem[33] = enc_s(12'd20, 5'd7, 5'd0, 3'b010);
    imem[34] = enc_s(12'd24, 5'd9, 5'd0, 3'b010);
    imem[35] = enc_b(13'd8, 5'd0, 5'd0, 3'b001);             // BNE not taken
    imem[36] = enc_b(13'd8, 5'd0, 5'd0, 3'b000);             // BEQ -> word 38
    imem[38] = enc_i(12'h0C1, 5'd0, 3'b000, 5'd5, OP_IMM);   // x5 = 0xC1
    imem[39] = enc_i(12'd0,  5'd5, 3'b000, 5'd1, OP_JALR);   // -> 0xC0, x1 = 0xA0
    imem[48] = enc_s(12'd32, 5'd1, 5'd0, 3'b010);
    imem[49] = enc_s(12'd6,  5'd2, 5'd1, 3'b001);            // SH x2,6(x1) ea=0xA6
    imem[50] = enc_j(21'd8, 5'd10);                          // JAL -> 0xD0, x10 = 0xCC
    imem[52] = enc_s(12'd36, 5'd10, 5'd0, 3'b010);
    imem[53] = enc_b(13'd12, 5'd0, 5'd0, 3'b000);            // -> 0xE0
    imem[54] = enc_i(12'h077, 5'd0, 3'b000, 5'd11, OP_IMM);
    imem[55] = enc_b(13'd12, 5'd0, 5'd0, 3'b000);            // -> 0xE8
    imem[56] = enc_b(13'h1FF8, 5'd0, 5'd0, 3'b000);          // back to 0xD8
    imem[58] = enc_s(12'd40, 5'd11, 5'd0, 3'b010);
    imem[59] = enc_i(12'd1,  5'd1, 3'b010, 5'd12, OP_LOAD);  // LW ea=0xA1
    exp_q.delete();
    push(30'h00, 4'hF, 32'hFFFFFFFE);
    push(30'h40, 4'h8, 32'h80808080);
    push(30'h01, 4'hF, 32'hFFFFFF80);
    push(30'h02, 4'hF, 32'h00000080);
    push(30'h03, 4'h3, 32'h80008000);
    push(30'h04, 4'hF, 32'h00000100);
    push(30'h05, 4'hF, 32'h00000001);
    push(30'h06, 4'hF, 32'hFFFFFFF8);
    push(30'h08, 4'hF, 32'h000000A0);
    push(30'h29, 4'hC, 32'h56805680);
    push(30'h09, 4'hF, 32'h000000CC);
    push(30'h0A, 4'hF, 32'h00000077);
  endtask

  // Memory responder and store monitor; ready for a cycle is decided at its negedge.
  initial begin
    st_t e;
    i_instr_ready = 1'b0;
    i_mem_ready   = 1'b0;
    forever begin
      @(negedge clk);
      i_instr_ready = (mode == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (mode == 0) begin
        i_mem_ready = 1'b0;
      end else if (mode == 1) begin
        i_mem_ready = 1'b1;
        if (o_mem_req && !o_mem_we && o_mem_mask == 4'b1100) begin
          lh_req_cycles++;
          chk("lh_addr_stable", 32'(o_mem_addr), 32'h40);
          if (lh_stall > 0) begin
            i_mem_ready = 1'b0;
            lh_stall--;
          end
        end
      end else begin
        i_mem_ready = ($urandom_range(0, 2) != 0);
      end
      if (o_mem_req && i_mem_ready && !rst) begin
        if (o_mem_we) begin
          if (exp_q.size() == 0) begin
            chk("store_extra", {o_mem_mask, 28'(o_mem_addr)}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("store_addr", 32'(o_mem_addr), 32'(e.addr));
            chk("store_mask", 32'(o_mem_mask), 32'(e.mask));
            chk("store_data", o_mem_data, e.data);
          end
          for (int b = 0; b < 4; b++)
            if (o_mem_mask[b]) dmem[o_mem_addr[7:0]][8*b +: 8] = o_mem_data[8*b +: 8];
        end else begin
          n_loads++;
        end
      end
      if (o_instr_req && i_instr_ready) fetch_cyc = cyc;
      if (o_halted && halt_cyc < 0) halt_cyc = cyc;
      cyc++;
    end
  end

  task automatic run_until_halt(input int budget);
    int n;
    n = 0;
    while (!o_halted && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk("halt_reached", 32'(o_halted), 32'd1);
  endtask

  task automatic check_halt(input string ph);
    chk({ph, "_pc"}, 32'(o_instr_addr), 32'h3B);
    chk({ph, "_retired"}, o_retired, 32'd32);
    chk({ph, "_sb_left"}, 32'(exp_q.size()), 32'd0);
    chk({ph, "_loads"}, 32'(n_loads), 32'd3);
    chk({ph, "_halt_lat"}, 32'(halt_cyc - fetch_cyc), 32'd2);
    repeat (4) begin
      @(negedge clk); #1;
      chk({ph, "_hold_ireq"}, 32'(o_instr_req), 32'd0);
      chk({ph, "_hold_mreq"}, 32'(o_mem_req), 32'd0);
      chk({ph, "_hold_pc"}, 32'(o_instr_addr), 32'h3B);
      chk({ph, "_hold_halt"}, 32'(o_halted), 32'd1);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    load_program();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ireq", 32'(o_instr_req), 32'd0);
    chk("rst_mreq", 32'(o_mem_req), 32'd0);
    chk("rst_we", 32'(o_mem_we), 32'd0);
    chk("rst_halt", 32'(o_halted), 32'd0);
    chk("rst_retired", o_retired, 32'd0);
    chk("rst_pc", 32'(o_instr_addr), 32'h10);

    // Phase 1: readies high except a 3-cycle stall on the LH.
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("f0_addr", 32'(o_instr_addr), 32'h10);
    chk("f0_req", 32'(o_instr_req), 32'd1);
    @(negedge clk); #1;
    chk("ex0_req", 32'(o_instr_req), 32'd0);
    @(negedge clk); #1;
    chk("f1_addr", 32'(o_instr_addr), 32'h11);
    chk("f1_req", 32'(o_instr_req), 32'd1);
    chk("f1_retired", o_retired, 32'd1);
    repeat (2) @(negedge clk);
    #1;
    chk("two_retired", o_retired, 32'd2);
    run_until_halt(400);
    check_halt("p1");
    chk("lh_req_cycles", 32'(lh_req_cycles), 32'd4);

    // Phase 2: reset in the middle of a stalled SW.
    @(negedge clk);
    rst  = 1'b1;
    mode = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!(o_mem_req && o_mem_we) && n < 40);
    chk("abort_st_req", 32'(o_mem_req && o_mem_we), 32'd1);
    chk("abort_st_addr", 32'(o_mem_addr), 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("abort_mreq", 32'(o_mem_req), 32'd0);
    chk("abort_we", 32'(o_mem_we), 32'd0);
    chk("abort_ireq", 32'(o_instr_req), 32'd0);
    chk("abort_retired", o_retired, 32'd0);

    // Phase 3: full program again with random stalls on both ports.
    load_program();
    mode     = 2;
    n_loads  = 0;
    halt_cyc = -1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("p3_first_addr", 32'(o_instr_addr), 32'h10);
    chk("p3_retired0", o_retired, 32'd0);
    run_until_halt(3000);
    check_halt("p3");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
